// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: RX/TX byte FIFOs, sticky overflow flags and a
// free-running cycle counter, all reached through one CPU load/store port.
module uart_mmio_ctrl #(
   parameter int RX_DEPTH = 8,
   parameter int TX_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] addr,
   input  logic        re,
   input  logic        we,
   input  logic [7:0]  wdata,
   output logic [31:0] rdata,
   output logic [7:0]  uart_din,
   output logic        uart_din_valid,
   input  logic        uart_din_ready,
   input  logic [7:0]  uart_dout,
   input  logic        uart_dout_valid,
   output logic        uart_dout_ready
);

   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
   localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);

   localparam logic [31:0] ADDR_STATUS = 32'h8000_0000;
   localparam logic [31:0] ADDR_RXDATA = 32'h8000_0004;
   localparam logic [31:0] ADDR_TXDATA = 32'h8000_0008;
   localparam logic [31:0] ADDR_ERROR  = 32'h8000_000C;
   localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0010;

   logic [7:0]       rx_mem_q [RX_DEPTH];
   logic [7:0]       rx_mem_d [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;

   logic [7:0]       tx_mem_q [TX_DEPTH];
   logic [7:0]       tx_mem_d [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;

   logic [1:0]  err_q, err_d;
   logic [31:0] cycle_cnt_q, cycle_cnt_d;

   logic rd_en, wr_en;
   logic rx_empty, rx_full, tx_empty, tx_full;
   logic rx_pop, rx_push, rx_ovf;
   logic tx_pop, tx_push, tx_req, tx_ovf;
   logic err_clr, cnt_clr;

   assign rd_en    = re & ~stall;
   assign wr_en    = we & ~stall;
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == TX_FULL_CNT);

   // A full FIFO still accepts a byte when a pop frees the slot in the same cycle.
   assign rx_pop  = rd_en & (addr == ADDR_RXDATA) & ~rx_empty;
   assign rx_push = uart_dout_valid & (~rx_full | rx_pop);
   assign rx_ovf  = uart_dout_valid & rx_full & ~rx_pop;

   assign tx_pop  = ~tx_empty & uart_din_ready;
   assign tx_req  = wr_en & (addr == ADDR_TXDATA);
   assign tx_push = tx_req & (~tx_full | tx_pop);
   assign tx_ovf  = tx_req & tx_full & ~tx_pop;

   assign err_clr = wr_en & (addr == ADDR_ERROR);
   assign cnt_clr = wr_en & (addr == ADDR_CYCLE);

   assign uart_din        = tx_mem_q[tx_rd_q];
   assign uart_din_valid  = ~tx_empty;
   assign uart_dout_ready = rst;

   always_comb begin
      rx_mem_d = rx_mem_q;
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      rx_cnt_d = rx_cnt_q;
      if (rx_push) begin
         rx_mem_d[rx_wr_q] = uart_dout;
         rx_wr_d = rx_wr_q + 1'b1;
      end
      if (rx_pop) rx_rd_d = rx_rd_q + 1'b1;
      if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
   end

   always_comb begin
      tx_mem_d = tx_mem_q;
      tx_wr_d  = tx_wr_q;
      tx_rd_d  = tx_rd_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_push) begin
         tx_mem_d[tx_wr_q] = wdata;
         tx_wr_d = tx_wr_q + 1'b1;
      end
      if (tx_pop) tx_rd_d = tx_rd_q + 1'b1;
      if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
   end

   // Set is applied after clear so a same-cycle overflow survives the clear.
   always_comb begin
      err_d = err_clr ? 2'b00 : err_q;
      err_d = err_d | {tx_ovf, rx_ovf};
      cycle_cnt_d = cnt_clr ? 32'd0 : cycle_cnt_q + 32'd1;
   end

   always_comb begin
      rdata = '0;
      if (re && rst) begin
         case (addr)
            ADDR_STATUS: rdata = {30'b0, ~rx_empty, ~tx_full};
            ADDR_RXDATA: if (!rx_empty) rdata = {24'b0, rx_mem_q[rx_rd_q]};
            ADDR_ERROR:  rdata = {30'b0, err_q};
            ADDR_CYCLE:  rdata = cycle_cnt_q;
            default:     rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_mem_q    <= '{default: '0};
         rx_wr_q     <= '0;
         rx_rd_q     <= '0;
         rx_cnt_q    <= '0;
         tx_mem_q    <= '{default: '0};
         tx_wr_q     <= '0;
         tx_rd_q     <= '0;
         tx_cnt_q    <= '0;
         err_q       <= '0;
         cycle_cnt_q <= '0;
      end else begin
         rx_mem_q    <= rx_mem_d;
         rx_wr_q     <= rx_wr_d;
         rx_rd_q     <= rx_rd_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_mem_q    <= tx_mem_d;
         tx_wr_q     <= tx_wr_d;
         tx_rd_q     <= tx_rd_d;
         tx_cnt_q    <= tx_cnt_d;
         err_q       <= err_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

endmodule
